// File: rtl/wb_chrono_ram_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_pkg                                                       |
// | Description : Shared definitions for the Wishbone chrono RAM slave:        |
// |               FSM state encodings, default bus widths and a helper that    |
// |               derives the byte-lane count from data width / granularity.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package wb_pkg;

  localparam int unsigned DEF_WB_DATA_WIDTH = 32;
  localparam int unsigned DEF_WB_ADDR_WIDTH = 11;
  localparam int unsigned DEF_GRANULARITY   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } wb_state_e;

  // Number of sel lanes for a given data width and lane granularity.
  function automatic int unsigned wb_lanes(input int unsigned dw, input int unsigned gran);
    return dw / gran;
  endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_chrono_ram_slave_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_ram_bank                                                  |
// | Description : Single-port RAM bank with per-lane write enables and a       |
// |               registered read port. The read register holds its value     |
// |               until the next read; memory contents are never reset.        |
// | Ports       : clk_i    - clock (rising edge)                               |
// |               rst_ni   - async active-low reset (read register only)       |
// |               en_i     - access enable                                     |
// |               we_i     - 1 = write, 0 = read (qualified by en_i)           |
// |               be_i     - lane write enables                                |
// |               addr_i   - word address                                      |
// |               wdata_i  - write data                                        |
// |               rdata_o  - registered read data                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_ram_bank
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_WB_ADDR_WIDTH - 1,
  parameter int unsigned GRANULARITY = DEF_GRANULARITY
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic                                we_i,
  input  logic [DATA_WIDTH/GRANULARITY-1:0]   be_i,
  input  logic [ADDR_WIDTH-1:0]               addr_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  output logic [DATA_WIDTH-1:0]               rdata_o
);

  localparam int unsigned LANES = wb_lanes(DATA_WIDTH, GRANULARITY);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][k*GRANULARITY +: GRANULARITY] <= wdata_i[k*GRANULARITY +: GRANULARITY];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : wb_ram_bank
`default_nettype wire

// File: rtl/wb_chrono_ram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_chrono_ram_slave                                          |
// | Description : Wishbone classic-cycle slave backed by two byte-addressable  |
// |               RAM banks. Address MSB selects the bank. Every accepted      |
// |               request completes with a one-cycle ack_o after WAIT_STATES   |
// |               wait cycles; dropping cyc_i/stb_i while waiting aborts it.   |
// | Options     : `define WB_ERR_EN adds err_o; a request with all sel lanes   |
// |               clear then completes with err_o instead of ack_o.            |
// | Ports       : clk_i   - clock (rising edge)                                |
// |               rst_ni  - async active-low reset                             |
// |               addr_i  - word address, MSB = bank select                    |
// |               data_i  - write data                                         |
// |               data_o  - read data, held until the next read ack            |
// |               sel_i   - byte-lane enables                                  |
// |               we_i    - 1 = write, 0 = read                                |
// |               stb_i   - strobe                                             |
// |               cyc_i   - bus cycle valid                                    |
// |               ack_o   - single-cycle completion                            |
// |               err_o   - single-cycle error completion (WB_ERR_EN only)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_chrono_ram_slave
  import wb_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH = DEF_WB_DATA_WIDTH,
  parameter int unsigned WB_ADDR_WIDTH = DEF_WB_ADDR_WIDTH,
  parameter int unsigned GRANULARITY   = DEF_GRANULARITY,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [WB_ADDR_WIDTH-1:0]              addr_i,
  input  logic [WB_DATA_WIDTH-1:0]              data_i,
  output logic [WB_DATA_WIDTH-1:0]              data_o,
  input  logic [WB_DATA_WIDTH/GRANULARITY-1:0]  sel_i,
  input  logic                                  we_i,
  input  logic                                  stb_i,
  input  logic                                  cyc_i,
  output logic                                  ack_o
`ifdef WB_ERR_EN
  ,
  output logic                                  err_o
`endif
);

  localparam int unsigned LANES     = wb_lanes(WB_DATA_WIDTH, GRANULARITY);
  localparam int unsigned WORD_AW   = WB_ADDR_WIDTH - 1;
  localparam logic [3:0]  LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_state_e                 state_q;
  logic [3:0]                cnt_q;
  logic [WB_ADDR_WIDTH-1:0]  addr_q;
  logic [WB_DATA_WIDTH-1:0]  data_q;
  logic [LANES-1:0]          sel_q;
  logic                      we_q;
  logic                      ack_q;
  logic                      rd_bank_q;

  logic                      req_valid;
  logic                      take_ack;
  logic [WB_ADDR_WIDTH-1:0]  req_addr;
  logic                      req_we;
  logic                      req_err;
  logic                      rd_en;
  logic                      wr_en;
  logic                      ram_bank;
  logic [WORD_AW-1:0]        ram_addr;
  logic [WB_DATA_WIDTH-1:0]  rdata0;
  logic [WB_DATA_WIDTH-1:0]  rdata1;

  assign req_valid = cyc_i & stb_i;

  // In IDLE the request is taken straight from the bus so a zero-wait
  // access can launch its RAM read on the acceptance edge; afterwards the
  // latched copy is used.
  assign req_addr = (state_q == IDLE) ? addr_i : addr_q;
  assign req_we   = (state_q == IDLE) ? we_i   : we_q;

`ifdef WB_ERR_EN
  logic [LANES-1:0] req_sel;
  logic             err_q;

  assign req_sel = (state_q == IDLE) ? sel_i : sel_q;
  assign req_err = ~|req_sel;
  assign err_o   = err_q;
`else
  assign req_err = 1'b0;
`endif

  // Asserted on the edge that moves the FSM into ACK.
  assign take_ack = req_valid &
                    (((state_q == IDLE) && (WAIT_STATES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == LAST_WAIT)));

  // Read is issued one edge early so data_o is valid throughout the ACK cycle.
  assign rd_en    = take_ack & ~req_we & ~req_err;
  // Write commits on the edge that closes the ACK cycle; an err completion
  // always has sel_q == 0 so no lane is touched.
  assign wr_en    = (state_q == ACK) & we_q;
  assign ram_bank = req_addr[WB_ADDR_WIDTH-1];
  assign ram_addr = req_addr[WORD_AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rd_bank_q <= 1'b0;
`ifdef WB_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q <= take_ack & ~req_err;
`ifdef WB_ERR_EN
      err_q <= take_ack & req_err;
`endif
      if (rd_en) begin
        rd_bank_q <= ram_bank;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= 4'd0;
          if (req_valid) begin
            addr_q  <= addr_i;
            data_q  <= data_i;
            sel_q   <= sel_i;
            we_q    <= we_i;
            state_q <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!req_valid) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == LAST_WAIT) begin
            state_q <= ACK;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ACK: begin
          // Always one IDLE cycle after completion before a new acceptance.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rd_bank_q ? rdata1 : rdata0;

  wb_ram_bank #(
    .DATA_WIDTH  (WB_DATA_WIDTH),
    .ADDR_WIDTH  (WORD_AW),
    .GRANULARITY (GRANULARITY)
  ) u_bank0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    ((rd_en | wr_en) & ~ram_bank),
    .we_i    (wr_en),
    .be_i    (sel_q),
    .addr_i  (ram_addr),
    .wdata_i (data_q),
    .rdata_o (rdata0)
  );

  wb_ram_bank #(
    .DATA_WIDTH  (WB_DATA_WIDTH),
    .ADDR_WIDTH  (WORD_AW),
    .GRANULARITY (GRANULARITY)
  ) u_bank1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    ((rd_en | wr_en) & ram_bank),
    .we_i    (wr_en),
    .be_i    (sel_q),
    .addr_i  (ram_addr),
    .wdata_i (data_q),
    .rdata_o (rdata1)
  );

endmodule : wb_chrono_ram_slave
`default_nettype wire

// File: tb/tb_wb_chrono_ram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_chrono_ram_slave                                       |
// | Description : Self-checking bench for wb_chrono_ram_slave. Two instances:  |
// |               u_dut1 (WAIT_STATES=1) and u_dut3 (WAIT_STATES=3) share the  |
// |               bus signals and have separate strobes. Honors WB_ERR_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_chrono_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] addr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb1, stb3;
  logic        ack1, ack3;
  logic [31:0] dat1, dat3;
  logic        err1, err3;

`ifndef WB_ERR_EN
  assign err1 = 1'b0;
  assign err3 = 1'b0;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  wb_chrono_ram_slave #(.WAIT_STATES(1)) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n), .addr_i (addr), .data_i (wdat), .data_o (dat1),
    .sel_i (sel), .we_i (we), .stb_i (stb1), .cyc_i (cyc), .ack_o (ack1)
`ifdef WB_ERR_EN
    , .err_o (err1)
`endif
  );

  wb_chrono_ram_slave #(.WAIT_STATES(3)) u_dut3 (
    .clk_i (clk), .rst_ni (rst_n), .addr_i (addr), .data_i (wdat), .data_o (dat3),
    .sel_i (sel), .we_i (we), .stb_i (stb3), .cyc_i (cyc), .ack_o (ack3)
`ifdef WB_ERR_EN
    , .err_o (err3)
`endif
  );

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
    logic [31:0] mask;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] sb_exp  [$];
  logic [31:0] sb_mask [$];

  function automatic vec_t mk(input logic w, input logic [10:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e, input logic [31:0] m);
    vec_t v;
    v.we = w; v.addr = a; v.wd = d; v.sel = s; v.exp = e; v.mask = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One bus cycle on instance d (1 or 3). lat/elat = edges after acceptance
  // at which ack/err was seen, -1 if never within the budget.
  task automatic bus(input int d, input logic w, input logic [10:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output int lat, output int elat, output logic [31:0] rd);
    logic done;
    done = 1'b0; lat = -1; elat = -1;
    @(negedge clk);
    addr = a; wdat = wd; sel = s; we = w; cyc = 1'b1;
    if (d == 1) stb1 = 1'b1; else stb3 = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if ((d == 1) ? ack1 : ack3) begin lat = i; done = 1'b1; end
      if ((d == 1) ? err1 : err3) begin elat = i; done = 1'b1; end
    end
    rd = (d == 1) ? dat1 : dat3;
    cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0;
    @(posedge clk); #1;
    check("resp_one_cycle", {31'b0, ((d == 1) ? (ack1 | err1) : (ack3 | err3))}, 32'd0);
  endtask

  int          lat, elat, n;
  logic [31:0] rd, e, m;

  initial begin
    rst_n = 1'b0; addr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0;
    stb1 = 1'b0; stb3 = 1'b0;

    vecs[0]  = mk(1'b1, 11'h00A, 32'h0000_1234, 4'b0011, 32'h0,          32'h0);
    vecs[1]  = mk(1'b0, 11'h00A, 32'h0,         4'b1111, 32'h0000_1234, 32'h0000_FFFF);
    vecs[2]  = mk(1'b1, 11'h010, 32'hAABB_CCDD, 4'b1111, 32'h0,          32'h0);
    vecs[3]  = mk(1'b1, 11'h010, 32'h0000_0011, 4'b0001, 32'h0,          32'h0);
    vecs[4]  = mk(1'b0, 11'h010, 32'h0,         4'b1111, 32'hAABB_CC11, 32'hFFFF_FFFF);
    vecs[5]  = mk(1'b1, 11'h003, 32'h0000_1111, 4'b1111, 32'h0,          32'h0);
    vecs[6]  = mk(1'b1, 11'h403, 32'h0000_2222, 4'b1111, 32'h0,          32'h0);
    vecs[7]  = mk(1'b0, 11'h003, 32'h0,         4'b1111, 32'h0000_1111, 32'hFFFF_FFFF);
    vecs[8]  = mk(1'b0, 11'h403, 32'h0,         4'b1111, 32'h0000_2222, 32'hFFFF_FFFF);
    vecs[9]  = mk(1'b1, 11'h7FF, 32'h1234_5678, 4'b1111, 32'h0,          32'h0);
    vecs[10] = mk(1'b1, 11'h3FF, 32'h8765_4321, 4'b1111, 32'h0,          32'h0);
    vecs[11] = mk(1'b0, 11'h7FF, 32'h0,         4'b1111, 32'h1234_5678, 32'hFFFF_FFFF);
    vecs[12] = mk(1'b0, 11'h3FF, 32'h0,         4'b1111, 32'h8765_4321, 32'hFFFF_FFFF);
    vecs[13] = mk(1'b1, 11'h010, 32'h5500_0000, 4'b1000, 32'h0,          32'h0);
    vecs[14] = mk(1'b0, 11'h010, 32'h0,         4'b0001, 32'h55BB_CC11, 32'hFFFF_FFFF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack1", {31'b0, ack1}, 32'd0);
    check("rst_ack3", {31'b0, ack3}, 32'd0);
    check("rst_dat1", dat1, 32'd0);
    check("rst_dat3", dat3, 32'd0);
`ifdef WB_ERR_EN
    check("rst_err1", {31'b0, err1}, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a write's wait phase
    bus(1, 1'b1, 11'h005, 32'hCAFE_F00D, 4'b1111, lat, elat, rd);
    check("pre_wr_lat", lat, 32'd1);
    bus(1, 1'b0, 11'h005, 32'h0, 4'b1111, lat, elat, rd);
    check("pre_rd_data", rd, 32'hCAFE_F00D);
    @(negedge clk);
    addr = 11'h005; wdat = 32'hDEAD_BEEF; sel = 4'b1111; we = 1'b1; cyc = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack1}, 32'd0);
    check("midrst_data", dat1, 32'd0);
    @(posedge clk); #1;
    check("midrst_ack_late", {31'b0, ack1}, 32'd0);
    cyc = 1'b0; stb1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bus(1, 1'b0, 11'h005, 32'h0, 4'b1111, lat, elat, rd);
    check("postrst_data", rd, 32'hCAFE_F00D);

    // Table-driven vectors on the one-wait-state instance
    for (int i = 0; i < 15; i++) begin
      if (!vecs[i].we) begin
        sb_exp.push_back(vecs[i].exp);
        sb_mask.push_back(vecs[i].mask);
      end
      bus(1, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].sel, lat, elat, rd);
      check($sformatf("vec%0d_lat", i), lat, 32'd1);
      if (!vecs[i].we && lat >= 0) begin
        e = sb_exp.pop_front();
        m = sb_mask.pop_front();
        check($sformatf("vec%0d_rdata", i), rd & m, e & m);
      end
    end

    // Three wait states: abort then back-to-back reads
    bus(3, 1'b1, 11'h050, 32'h1111_2222, 4'b1111, lat, elat, rd);
    check("ws3_wr_lat", lat, 32'd3);
    bus(3, 1'b1, 11'h051, 32'h3333_4444, 4'b1111, lat, elat, rd);
    check("ws3_wr2_lat", lat, 32'd3);
    @(negedge clk);
    addr = 11'h050; wdat = 32'h9999_9999; sel = 4'b1111; we = 1'b1; cyc = 1'b1; stb3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb3 = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack3) n++;
    end
    check("abort_no_ack", n, 32'd0);
    sb_exp.push_back(32'h1111_2222);
    bus(3, 1'b0, 11'h050, 32'h0, 4'b1111, lat, elat, rd);
    check("b2b_rd1_lat", lat, 32'd3);
    check("b2b_rd1_data", rd, sb_exp.pop_front());
    sb_exp.push_back(32'h3333_4444);
    bus(3, 1'b0, 11'h051, 32'h0, 4'b1111, lat, elat, rd);
    check("b2b_rd2_lat", lat, 32'd3);
    check("b2b_rd2_data", rd, sb_exp.pop_front());

    // sel == 0 requests
    bus(1, 1'b1, 11'h020, 32'h1357_9BDF, 4'b1111, lat, elat, rd);
    bus(1, 1'b1, 11'h021, 32'h2468_ACE0, 4'b1111, lat, elat, rd);
    bus(1, 1'b0, 11'h020, 32'h0, 4'b1111, lat, elat, rd);
    check("sel0_setup", rd, 32'h1357_9BDF);
    bus(1, 1'b1, 11'h020, 32'hFFFF_FFFF, 4'b0000, lat, elat, rd);
`ifdef WB_ERR_EN
    check("sel0_wr_err_lat", elat, 32'd1);
    check("sel0_wr_no_ack", lat, 32'hFFFF_FFFF);
    check("sel0_wr_data_held", rd, 32'h1357_9BDF);
`else
    check("sel0_wr_ack_lat", lat, 32'd1);
`endif
    bus(1, 1'b0, 11'h020, 32'h0, 4'b1111, lat, elat, rd);
    check("sel0_wr_no_write", rd, 32'h1357_9BDF);
    bus(1, 1'b0, 11'h021, 32'h0, 4'b0000, lat, elat, rd);
`ifdef WB_ERR_EN
    check("sel0_rd_err_lat", elat, 32'd1);
    check("sel0_rd_no_ack", lat, 32'hFFFF_FFFF);
    check("sel0_rd_data_held", rd, 32'h1357_9BDF);
`else
    check("sel0_rd_ack_lat", lat, 32'd1);
    check("sel0_rd_data", rd, 32'h2468_ACE0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_chrono_ram_slave
`default_nettype wire
